// File: rtl/kyber_phase_seq_if.sv
// kyber_phase_seq_if: control/step-stream bundle between the Kyber controller and kyber_phase_seq
// master: controller side (drives start/abort/mode/step_rdy, observes the step stream)
// slave:  sequencer side (observes controls, drives step stream and status)
interface kyber_phase_seq_if #(
  parameter int CNT_W = 7,
  parameter int SEG_W = 4,
  parameter int REP_W = 3
);
  logic             start;
  logic             abort;
  logic             sel;
  logic [2:0]       k;
  logic [REP_W-1:0] reps;
  logic             step_rdy;
  logic             step_vld;
  logic [CNT_W-1:0] step_cnt;
  logic [SEG_W-1:0] seg_idx;
  logic             seg_first;
  logic             eta3;
  logic             pass_end;
  logic             last;
  logic             busy;
  logic             done;
  logic             mode_err;
  modport master (
    output start, abort, sel, k, reps, step_rdy,
    input  step_vld, step_cnt, seg_idx, seg_first, eta3, pass_end, last, busy, done, mode_err
  );
  modport slave (
    input  start, abort, sel, k, reps, step_rdy,
    output step_vld, step_cnt, seg_idx, seg_first, eta3, pass_end, last, busy, done, mode_err
  );
endinterface

// File: rtl/kyber_phase_seq.sv
// kyber_phase_seq: stallable per-mode phase-schedule step generator for the Kyber core
// Ports: clk; rst_n (async, active-low); seq (kyber_phase_seq_if.slave):
//   in  start, abort, sel, k[2:0], reps[REP_W-1:0], step_rdy
//   out step_vld, step_cnt, seg_idx, seg_first, eta3, pass_end, last, busy, done, mode_err
// Build option: define KYBER_ETA3_EN to include the eta3 decode; otherwise eta3 is tied to 0.
module kyber_phase_seq #(
  parameter int CNT_W = 7,
  parameter int SEG_W = 4,
  parameter int REP_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  kyber_phase_seq_if.slave seq
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d, mode_in;
  logic             err_q, err_d, err_in;
  logic [REP_W-1:0] reps_q, reps_d, rep_q, rep_d, rep_tgt;
  logic [CNT_W-1:0] step_q, step_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [4:0]       pos_q, pos_d;
  logic [8:0][4:0]  tbl;
  logic [6:0]       plen;
  logic             vld, hs, seg_end, p_end, lst, eta;
  // mode index: 0..2 = sel0,k2..4; 3..5 = sel1,k2..4; anything unsupported runs mode 5
  assign err_in  = !(seq.k inside {3'd2, 3'd3, 3'd4});
  assign mode_in = err_in ? 3'd5 : (seq.k - 3'd2) + (seq.sel ? 3'd3 : 3'd0);
  // segment lengths, segment 0 in the lowest slot
  always_comb begin
    tbl  = {5'd1, 5'd1, 5'd13, 5'd18, 5'd16, 5'd13, 5'd1, 5'd5, 5'd5};
    plen = 7'd73;
    case (mode_q)
      3'd0: begin tbl = {25'd0, 5'd6, 5'd6, 5'd6, 5'd6}; plen = 7'd24; end
      3'd1: begin tbl = {15'd0, 5'd9, 5'd13, 5'd9, 5'd1, 5'd5, 5'd5}; plen = 7'd42; end
      3'd2: begin tbl = {5'd0, 5'd12, 5'd18, 5'd17, 5'd13, 5'd1, 5'd1, 5'd5, 5'd5}; plen = 7'd72; end
      3'd3: begin tbl = {20'd0, 5'd1, 5'd1, 5'd5, 5'd10, 5'd6}; plen = 7'd23; end
      3'd4: begin tbl = {10'd0, 5'd1, 5'd1, 5'd9, 5'd13, 5'd9, 5'd5, 5'd5}; plen = 7'd43; end
      default: ;
    endcase
  end
  assign vld     = state_q == RUN;
  assign hs      = vld && seq.step_rdy;
  assign seg_end = pos_q == tbl[seg_q[3:0]] - 5'd1;
  assign p_end   = vld && step_q == CNT_W'(plen - 7'd1);
  // reps of 0 behaves as a single pass
  assign rep_tgt = reps_q == '0 ? '0 : reps_q - REP_W'(1);
  assign lst     = p_end && rep_q == rep_tgt;
`ifdef KYBER_ETA3_EN
  assign eta = vld && pos_q < 5'd2 && (mode_q == 3'd0 || (mode_q == 3'd3 && seg_q < SEG_W'(2)));
`else
  assign eta = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    reps_d  = reps_q;
    rep_d   = rep_q;
    step_d  = step_q;
    seg_d   = seg_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: if (seq.start && !seq.abort) begin
        state_d = RUN;
        mode_d  = mode_in;
        err_d   = err_in;
        reps_d  = seq.reps;
        rep_d   = '0;
        step_d  = '0;
        seg_d   = '0;
        pos_d   = '0;
      end
      RUN: if (seq.abort) state_d = IDLE;
      else if (hs) begin
        state_d = lst ? FIN : RUN;
        step_d  = p_end ? '0 : step_q + CNT_W'(1);
        seg_d   = p_end ? '0 : seg_end ? seg_q + SEG_W'(1) : seg_q;
        pos_d   = (p_end || seg_end) ? '0 : pos_q + 5'd1;
        rep_d   = p_end ? rep_q + REP_W'(1) : rep_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      err_q   <= 1'b0;
      reps_q  <= '0;
      rep_q   <= '0;
      step_q  <= '0;
      seg_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
      pos_q   <= pos_d;
    end
  end
  assign seq.step_vld  = vld;
  assign seq.step_cnt  = vld ? step_q : '0;
  assign seq.seg_idx   = vld ? seg_q : '0;
  assign seq.seg_first = vld && pos_q == '0;
  assign seq.eta3      = eta;
  assign seq.pass_end  = p_end;
  assign seq.last      = lst;
  assign seq.busy      = state_q != IDLE;
  assign seq.done      = state_q == FIN;
  assign seq.mode_err  = err_q;
endmodule

// File: tb/tb_kyber_phase_seq.sv
// tb_kyber_phase_seq: self-checking bench for kyber_phase_seq against a schedule-list model
module tb_kyber_phase_seq;
  typedef struct packed {
    logic [6:0] cnt;
    logic [3:0] seg;
    logic       first;
    logic       eta;
    logic       pend;
    logic       last;
  } step_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  kyber_phase_seq_if #(.CNT_W(7), .SEG_W(4), .REP_W(3)) bus ();
  kyber_phase_seq #(.CNT_W(7), .SEG_W(4), .REP_W(3)) dut (.clk(clk), .rst_n(rst_n), .seq(bus));
  logic [18:0] dut_vec;
  assign dut_vec = {bus.step_vld, bus.step_cnt, bus.seg_idx, bus.seg_first, bus.eta3,
                    bus.pass_end, bus.last, bus.busy, bus.done, bus.mode_err};
  step_t exp_q[$];
  int    m_idx = 0;
  int    m_phase = 0;
  bit    m_err = 1'b0;
  function automatic void build(input bit s, input bit [2:0] kk, input bit [2:0] r);
    int lens[$];
    int n;
    int cnt;
    step_t st;
    exp_q.delete();
    n = (r == 0) ? 1 : int'(r);
    m_err = !(kk inside {3'd2, 3'd3, 3'd4});
    if (!s && kk == 2) lens = '{6, 6, 6, 6};
    else if (!s && kk == 3) lens = '{5, 5, 1, 9, 13, 9};
    else if (!s && kk == 4) lens = '{5, 5, 1, 1, 13, 17, 18, 12};
    else if (s && kk == 2) lens = '{6, 10, 5, 1, 1};
    else if (s && kk == 3) lens = '{5, 5, 9, 13, 9, 1, 1};
    else lens = '{5, 5, 1, 13, 16, 18, 13, 1, 1};
    for (int p = 0; p < n; p++) begin
      cnt = 0;
      for (int si = 0; si < lens.size(); si++) begin
        for (int j = 0; j < lens[si]; j++) begin
          st.cnt = 7'(cnt);
          st.seg = 4'(si);
          st.first = (j == 0);
`ifdef KYBER_ETA3_EN
          st.eta = (j < 2) && kk == 2 && (!s || si < 2);
`else
          st.eta = 1'b0;
`endif
          st.pend = 1'b0;
          st.last = 1'b0;
          exp_q.push_back(st);
          cnt++;
        end
      end
      exp_q[exp_q.size()-1].pend = 1'b1;
    end
    exp_q[exp_q.size()-1].last = 1'b1;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_err = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.start && !bus.abort) begin
          build(bus.sel, bus.k, bus.reps);
          m_idx = 0;
          m_phase = 1;
        end
        1: if (bus.abort) m_phase = 0;
        else if (bus.step_rdy) begin
          if (m_idx == exp_q.size() - 1) m_phase = 2;
          m_idx++;
        end
        default: m_phase = 0;
      endcase
    end
  end
  int obs_hs, obs_vld, obs_done, obs_seg_max;
  logic [255:0] first_m, eta_m, pend_m, last_m;
  always @(negedge clk) begin : cmp
    step_t e;
    logic [18:0] ev;
    e = (m_phase == 1) ? exp_q[m_idx] : '0;
    ev = {m_phase == 1, e, m_phase != 0, m_phase == 2, m_err};
    n_chk++;
    if (dut_vec !== ev) begin
      n_fail++;
      $display("FAIL outputs t=%0t: got %h expected %h", $time, dut_vec, ev);
    end
    if (bus.start && !bus.abort && m_phase == 0) begin
      obs_hs = 0; obs_vld = 0; obs_done = 0; obs_seg_max = 0;
      first_m = '0; eta_m = '0; pend_m = '0; last_m = '0;
    end else begin
      if (bus.step_vld && bus.step_rdy && obs_hs < 256) begin
        first_m[obs_hs] = bus.seg_first;
        eta_m[obs_hs] = bus.eta3;
        pend_m[obs_hs] = bus.pass_end;
        last_m[obs_hs] = bus.last;
        obs_hs++;
      end
      if (bus.step_vld) obs_vld++;
      if (bus.done) obs_done++;
      if (bus.step_vld && int'(bus.seg_idx) > obs_seg_max) obs_seg_max = int'(bus.seg_idx);
    end
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chkv(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input bit s, input bit [2:0] kk, input bit [2:0] r);
    step();
    bus.start = 1'b1; bus.sel = s; bus.k = kk; bus.reps = r; bus.step_rdy = 1'b1;
    step();
    bus.start = 1'b0; bus.sel = ~s; bus.k = 3'd6; bus.reps = 3'd0;
  endtask
  task automatic run_to_idle(input bit tog, input int budget);
    for (int i = 0; i < budget && bus.busy; i++) begin
      step();
      bus.step_rdy = tog ? ~bus.step_rdy : 1'b1;
    end
    chk("run_timeout", bus.busy, 0);
  endtask
  task automatic run_to_step(input int target);
    for (int i = 0; i < 500 && !(bus.step_vld && int'(bus.step_cnt) == target); i++) step();
    chk("reach_step", bus.step_cnt, target);
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.sel = 1'b0; bus.k = 3'd0; bus.reps = 3'd0;
    bus.step_rdy = 1'b1;
    repeat (3) step();
    chk("reset_outputs", dut_vec, 0);
    rst_n = 1'b1;
    do_start(1'b0, 3'd2, 3'd1);
    chk("start_latency_vld", bus.step_vld, 1);
    chk("start_step0_first", bus.seg_first, 1);
    run_to_idle(1'b0, 200);
    chk("k2_handshakes", obs_hs, 24);
    chk("k2_vld_cycles", obs_vld, 24);
    chkv("k2_seg_first", first_m, 256'h41041);
`ifdef KYBER_ETA3_EN
    chkv("k2_eta3", eta_m, 256'hC30C3);
`else
    chkv("k2_eta3_off", eta_m, 256'h0);
`endif
    chkv("k2_last", last_m, 256'h800000);
    chk("k2_done", obs_done, 1);
    do_start(1'b1, 3'd4, 3'd3);
    run_to_idle(1'b0, 500);
    chk("k4r3_handshakes", obs_hs, 219);
    chkv("k4r3_pass_end", pend_m, (256'd1 << 72) | (256'd1 << 145) | (256'd1 << 218));
    chkv("k4r3_last", last_m, 256'd1 << 218);
    chk("k4r3_seg_max", obs_seg_max, 8);
    do_start(1'b0, 3'd3, 3'd1);
    run_to_idle(1'b1, 500);
    chk("k3_stall_vld_cycles", obs_vld, 83);
    chk("k3_stall_handshakes", obs_hs, 42);
    chkv("k3_seg_first", first_m, (256'd1 << 0) | (256'd1 << 5) | (256'd1 << 10) |
         (256'd1 << 11) | (256'd1 << 20) | (256'd1 << 33));
    do_start(1'b0, 3'd7, 3'd1);
    chk("mode_err_set", bus.mode_err, 1);
    run_to_idle(1'b0, 300);
    chk("bad_mode_handshakes", obs_hs, 73);
    chk("mode_err_held", bus.mode_err, 1);
    do_start(1'b1, 3'd2, 3'd0);
    chk("mode_err_cleared", bus.mode_err, 0);
    run_to_idle(1'b0, 200);
    chk("reps0_handshakes", obs_hs, 23);
    do_start(1'b1, 3'd3, 3'd1);
    run_to_step(10);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_idle_busy", bus.busy, 0);
    chk("abort_idle_vld", bus.step_vld, 0);
    step();
    chk("abort_no_done", obs_done, 0);
    do_start(1'b1, 3'd3, 3'd1);
    chk("restart_step0", bus.step_cnt, 0);
    run_to_idle(1'b0, 200);
    chk("restart_handshakes", obs_hs, 43);
    do_start(1'b0, 3'd4, 3'd1);
    run_to_step(30);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", dut_vec, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", dut_vec, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kyber_phase_seq.md
# kyber_phase_seq

Sequential phase-schedule generator for the Kyber core. It latches a parameter-set selection, then walks a fixed per-mode step schedule one step per accepted handshake. Each step carries segment-start, eta3 and end-of-pass markers, and the schedule can repeat a programmable number of passes. It sits between the Kyber top-level controller and the sampling/arithmetic datapath, and replaces static 73-bit pattern decoding with a stallable, cycle-accurate step stream.

## Interface
- `CNT_W`, default 7: step-counter width; must be ≥ 7, since the longest pass is 73 steps.
- `SEG_W`, default 4: segment-index width; must be ≥ 4, since the longest schedule has 9 segments.
- `REP_W`, default 3: repetition-count width.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a run; accepted only in IDLE.
- `abort`  in  1  synchronous abort; return to IDLE.
- `sel`  in  1  schedule family select.
- `k`  in  3  module rank (2, 3 or 4).
- `reps`  in  REP_W  pass count; 0 is treated as 1.
- `step_rdy`  in  1  downstream accepts the current step.
- `step_vld`  out  1  a step is presented.
- `step_cnt`  out  CNT_W  step index within the current pass.
- `seg_idx`  out  SEG_W  segment index within the current pass.
- `seg_first`  out  1  current step is the first step of a segment.
- `eta3`  out  1  current step is an eta3 step.
- `pass_end`  out  1  last step of the current pass.
- `last`  out  1  last step of the final pass.
- `busy`  out  1  run in progress (RUN or FIN).
- `done`  out  1  one-cycle completion pulse.
- `mode_err`  out  1  latched mode was unsupported; held until the next accepted start.

## Operation
- Schedules are lists of segment lengths, indexed by the latched {sel,k}:
  - 0,2: 6,6,6,6 (24 steps).
  - 0,3: 5,5,1,9,13,9 (42 steps).
  - 0,4: 5,5,1,1,13,17,18,12 (72 steps).
  - 1,2: 6,10,5,1,1 (23 steps).
  - 1,3: 5,5,9,13,9,1,1 (43 steps).
  - 1,4: 5,5,1,13,16,18,13,1,1 (73 steps).
- Any other {sel,k} runs the 1,4 schedule and sets `mode_err`.
- eta3 steps:
  - 0,2: steps 0,1 of every segment.
  - 1,2: steps 0,1 of segments 0 and 1.
  - All other modes: none.
- FSM states are IDLE, RUN and FIN.
  - IDLE→RUN on `start`. `sel`, `k` and `reps` are latched at this point; counters are cleared.
  - In RUN, each handshake (`step_vld`&&`step_rdy`) advances `step_cnt`.
  - On a segment boundary, `seg_idx` increments.
  - On `pass_end`, `step_cnt` and `seg_idx` return to 0 and the repetition counter increments.
  - A handshake with `last`=1 moves RUN→FIN.
  - FIN→IDLE after one cycle; `done`=1 during FIN.
- `abort` in RUN or FIN moves to IDLE next cycle, with no `done` pulse. `abort` has priority over a same-cycle handshake.
- `start` in RUN or FIN is ignored.
- `start` and `abort` together in IDLE: stay in IDLE.
- Mode inputs are not sampled after start; changes mid-run have no effect.
- The step outputs (`step_cnt`, `seg_idx`, `seg_first`, `eta3`, `pass_end`, `last`) are decoded from registered counters.
- Those step outputs are valid only while `step_vld`=1 and are 0 otherwise.

## Timing
- Reset values: FSM=IDLE, all counters 0, every output 0 (including `mode_err`).
- Start latency: `start` at cycle n gives `step_vld`=1 with step 0 at cycle n+1.
- Throughput: one step per cycle while `step_rdy`=1.
- Stall: with `step_rdy`=0, all step outputs hold stable.
- Completion: the final handshake at cycle m gives `done`=1 and `busy`=1 at m+1, then `busy`=0 at m+2.
- A new `start` is accepted at m+2 at the earliest.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronous).

## Configuration
- `KYBER_ETA3_EN` defined: the eta3 decode is present and behaves as specified above.
- `KYBER_ETA3_EN` undefined: the eta3 decode is removed and `eta3` is tied to 0. Schedules and all other behaviour are unchanged.

## Test plan
- Mode sel=0,k=2, reps=1, `step_rdy` held at 1:
  - `step_vld` is high for 24 cycles.
  - `seg_first` is high at steps 0,6,12,18.
  - `eta3` is high at steps 0,1,6,7,12,13,18,19.
  - `last` is high at step 23; `done` pulses one cycle later.
- Mode sel=1,k=4, reps=3:
  - 219 handshakes in total.
  - `pass_end` is high at steps 72, 145 and 218 (counted from run start).
  - `last` is high only at 218.
  - `seg_idx` reaches 8 in each pass.
- Mode sel=0,k=3 with `step_rdy` toggling 1,0,1,0:
  - Outputs hold during each 0 cycle.
  - The run takes 83 cycles to `last` (42 handshakes, stalls between).
  - The segment starts occur on steps 0,5,10,11,20,33.
- Mode sel=0,k=7:
  - Runs the 73-step 1,4 schedule.
  - `mode_err`=1 from the cycle after start until the next accepted start.
- Abort at step 10 of mode sel=1,k=3:
  - IDLE on the next cycle, no `done`.
  - A restart then produces step 0 correctly.
- `rst_n` dropped at step 30 of mode sel=0,k=4: all outputs go to 0 immediately.
- Build without `KYBER_ETA3_EN`, mode sel=0,k=2: `eta3` stays 0 for the whole run.
